// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side frame controller: state encoding,
// drop-reason codes and the default start-of-frame marker.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
  localparam logic [1:0] ERR_FRAMING  = 2'd1;
  localparam logic [1:0] ERR_LENGTH   = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: register array with one synchronous write port and one
// asynchronous read port; storage is deliberately left unreset.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Packet controller behind the byte UART receiver: hunts for sync, checks length
// and XOR checksum, buffers the payload and releases verified frames on a stream.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 104167
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_error,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  state_t        state, state_n;
  logic [7:0]    frame_len, frame_len_n;
  logic [7:0]    csum, csum_n;
  logic [AW-1:0] wr_idx, wr_idx_n;
  logic [AW-1:0] rd_idx, rd_idx_n;
  logic [CW-1:0] tcnt, tcnt_n;
  logic          frame_ok_n, frame_err_n, overrun_n;
  logic [1:0]    err_code_n;
  logic          buf_we;
  logic          timed_out;
  logic [7:0]    buf_rdata;

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx),
    .wdata (rx_data),
    .raddr (rd_idx_n),
    .rdata (buf_rdata)
  );

  assign timed_out = (tcnt == CW'(TIMEOUT_CLKS - 1));

  // Next-state logic; an arriving byte always takes priority over the timeout.
  always_comb begin
    state_n     = state;
    frame_len_n = frame_len;
    csum_n      = csum;
    wr_idx_n    = wr_idx;
    rd_idx_n    = rd_idx;
    tcnt_n      = '0;
    frame_ok_n  = 1'b0;
    frame_err_n = 1'b0;
    err_code_n  = err_code;
    overrun_n   = 1'b0;
    buf_we      = 1'b0;

    case (state)
      HUNT: begin
        if (rx_done && !rx_error && rx_data == SYNC_BYTE) state_n = LEN;
      end
      LEN: begin
        if (rx_done) begin
          if (rx_error) begin
            frame_err_n = 1'b1; err_code_n = ERR_FRAMING; state_n = HUNT;
          end else if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            frame_err_n = 1'b1; err_code_n = ERR_LENGTH; state_n = HUNT;
          end else begin
            frame_len_n = rx_data;
            csum_n      = rx_data;
            wr_idx_n    = '0;
            state_n     = PAYLOAD;
          end
        end else if (timed_out) begin
          frame_err_n = 1'b1; err_code_n = ERR_TIMEOUT; state_n = HUNT;
        end else begin
          tcnt_n = tcnt + CW'(1);
        end
      end
      PAYLOAD: begin
        if (rx_done) begin
          if (rx_error) begin
            frame_err_n = 1'b1; err_code_n = ERR_FRAMING; state_n = HUNT;
          end else begin
            buf_we   = 1'b1;
            csum_n   = csum ^ rx_data;
            wr_idx_n = wr_idx + AW'(1);
            if (8'(wr_idx) == frame_len - 8'd1) state_n = CSUM;
          end
        end else if (timed_out) begin
          frame_err_n = 1'b1; err_code_n = ERR_TIMEOUT; state_n = HUNT;
        end else begin
          tcnt_n = tcnt + CW'(1);
        end
      end
      CSUM: begin
        if (rx_done) begin
          if (rx_error) begin
            frame_err_n = 1'b1; err_code_n = ERR_FRAMING; state_n = HUNT;
          end else if (rx_data != csum) begin
            frame_err_n = 1'b1; err_code_n = ERR_CHECKSUM; state_n = HUNT;
          end else begin
            frame_ok_n = 1'b1;
            rd_idx_n   = '0;
            state_n    = DRAIN;
          end
        end else if (timed_out) begin
          frame_err_n = 1'b1; err_code_n = ERR_TIMEOUT; state_n = HUNT;
        end else begin
          tcnt_n = tcnt + CW'(1);
        end
      end
      DRAIN: begin
        overrun_n = rx_done;
        if (out_valid && out_ready) begin
          if (out_last) state_n = HUNT;
          else          rd_idx_n = rd_idx + AW'(1);
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Stream outputs are computed from next-state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      frame_len <= '0;
      csum      <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      tcnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      frame_len <= frame_len_n;
      csum      <= csum_n;
      wr_idx    <= wr_idx_n;
      rd_idx    <= rd_idx_n;
      tcnt      <= tcnt_n;
      out_data  <= (state_n == DRAIN) ? buf_rdata : 8'h00;
      out_valid <= (state_n == DRAIN);
      out_last  <= (state_n == DRAIN) && (8'(rd_idx_n) == frame_len_n - 8'd1);
      frame_ok  <= frame_ok_n;
      frame_err <= frame_err_n;
      err_code  <= err_code_n;
      overrun   <= overrun_n;
      busy      <= (state_n != HUNT);
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scenario bench for uart_rx_frame_ctrl: expected frame events and payload bytes
// are queued as stimulus is sent and matched against what the DUT emits.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned TO_CLKS = 40;
  localparam int unsigned IDLE_BUDGET = 300;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int ovr_total = 0;
  int valid_total = 0;

  // Item encoding: [11:10] kind (1 byte, 2 frame_ok, 3 frame_err), [8] last, [7:0] data/code
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(TO_CLKS)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .overrun(overrun),
    .busy(busy)
  );

  function automatic logic [11:0] mk_byte(input logic last, input logic [7:0] d);
    return {2'd1, 1'b0, last, d};
  endfunction
  function automatic logic [11:0] mk_ok();
    return {2'd2, 10'd0};
  endfunction
  function automatic logic [11:0] mk_err(input logic [1:0] c);
    return {2'd3, 8'd0, c};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_ok) obs_q.push_back(mk_ok());
      if (frame_err) obs_q.push_back(mk_err(err_code));
      if (out_valid && out_ready) obs_q.push_back(mk_byte(out_last, out_data));
      if (overrun) ovr_total++;
      if (out_valid) valid_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_data = b; rx_error = e; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    tick();
    tick();
  endtask

  task automatic send_frame(input byte_q_t f);
    foreach (f[i]) send_byte(f[i], 1'b0);
  endtask

  task automatic wait_idle(output bit expired);
    int n = 0;
    while (busy && n < IDLE_BUDGET) begin
      tick();
      n++;
    end
    expired = (n >= IDLE_BUDGET);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rx_error = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({out_valid, out_last, frame_ok, frame_err, overrun, busy, err_code, out_data} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b ok=%b err=%b ovr=%b busy=%b code=%0d data=%h required all zero",
               out_valid, out_last, frame_ok, frame_err, overrun, busy, err_code, out_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_good_frame();
    bit expired; logic [11:0] e, o; int v0;
    v0 = valid_total;
    exp_q.push_back(mk_ok());
    exp_q.push_back(mk_byte(1'b0, 8'h11));
    exp_q.push_back(mk_byte(1'b0, 8'h22));
    exp_q.push_back(mk_byte(1'b1, 8'h33));
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    wait_idle(expired);
    checks++;
    if (expired) begin failures++; $display("FAIL good_idle: busy still %b after budget, required 0", busy); end
    checks++;
    if (valid_total - v0 != 3) begin failures++; $display("FAIL good_valid_cycles: got %0d required 3", valid_total - v0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL good_sb: got nothing required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL good_sb: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL good_extra: got %0d extra items (first %h) required 0", obs_q.size(), obs_q[0]); obs_q.delete(); end
  endtask

  task automatic test_bad_csum();
    bit expired; logic [11:0] e, o; int v0;
    v0 = valid_total;
    exp_q.push_back(mk_err(2'd3));
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
    wait_idle(expired);
    checks++;
    if (valid_total != v0) begin failures++; $display("FAIL csum_no_valid: got %0d valid cycles required 0", valid_total - v0); end
    exp_q.push_back(mk_ok());
    exp_q.push_back(mk_byte(1'b0, 8'h11));
    exp_q.push_back(mk_byte(1'b0, 8'h22));
    exp_q.push_back(mk_byte(1'b1, 8'h33));
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    wait_idle(expired);
    checks++;
    if (expired) begin failures++; $display("FAIL csum_idle: busy still %b after budget, required 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL csum_sb: got nothing required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL csum_sb: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL csum_extra: got %0d extra items (first %h) required 0", obs_q.size(), obs_q[0]); obs_q.delete(); end
  endtask

  task automatic test_length();
    bit expired; logic [11:0] e, o;
    byte_q_t f;
    logic [7:0] cs;
    exp_q.push_back(mk_err(2'd2));
    send_frame('{8'hA5, 8'h00});
    wait_idle(expired);
    exp_q.push_back(mk_err(2'd2));
    send_frame('{8'hA5, 8'h11});
    wait_idle(expired);
    // Maximum-length frame with a bench-computed checksum.
    f = '{8'hA5, 8'h10};
    cs = 8'h10;
    exp_q.push_back(mk_ok());
    for (int i = 0; i < 16; i++) begin
      f.push_back(8'(i * 7 + 3));
      cs = cs ^ 8'(i * 7 + 3);
      exp_q.push_back(mk_byte(i == 15, 8'(i * 7 + 3)));
    end
    f.push_back(cs);
    send_frame(f);
    wait_idle(expired);
    checks++;
    if (expired) begin failures++; $display("FAIL len_idle: busy still %b after budget, required 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL len_sb: got nothing required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL len_sb: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL len_extra: got %0d extra items (first %h) required 0", obs_q.size(), obs_q[0]); obs_q.delete(); end
  endtask

  task automatic test_garbage();
    bit expired; logic [11:0] e, o;
    send_frame('{8'h00, 8'hFF, 8'h5A});
    checks++;
    if (busy !== 1'b0 || obs_q.size() != 0) begin
      failures++; $display("FAIL garbage_ignored: got busy=%b items=%0d required busy=0 items=0", busy, obs_q.size());
    end
    exp_q.push_back(mk_ok());
    exp_q.push_back(mk_byte(1'b1, 8'h7E));
    send_frame('{8'hA5, 8'h01, 8'h7E, 8'h7F});
    wait_idle(expired);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL garbage_sb: got nothing required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL garbage_sb: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL garbage_extra: got %0d extra items (first %h) required 0", obs_q.size(), obs_q[0]); obs_q.delete(); end
  endtask

  task automatic test_framing_timeout();
    bit expired; logic [11:0] e, o;
    exp_q.push_back(mk_err(2'd1));
    send_frame('{8'hA5, 8'h03, 8'h11});
    send_byte(8'h22, 1'b1);
    wait_idle(expired);
    exp_q.push_back(mk_err(2'd0));
    send_frame('{8'hA5, 8'h03, 8'h11});
    repeat (TO_CLKS - 8) tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL timeout_early: busy=%b before terminal count, required 1", busy); end
    wait_idle(expired);
    checks++;
    if (expired) begin failures++; $display("FAIL timeout_idle: busy still %b after budget, required 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL fr_to_sb: got nothing required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL fr_to_sb: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL fr_to_extra: got %0d extra items (first %h) required 0", obs_q.size(), obs_q[0]); obs_q.delete(); end
  endtask

  task automatic test_overrun();
    bit expired; logic [11:0] e, o; int ov0;
    ov0 = ovr_total;
    out_ready = 1'b0;
    exp_q.push_back(mk_ok());
    exp_q.push_back(mk_byte(1'b0, 8'h11));
    exp_q.push_back(mk_byte(1'b0, 8'h22));
    exp_q.push_back(mk_byte(1'b1, 8'h33));
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b required 1", out_valid); end
    send_byte(8'hA5, 1'b0);
    send_byte(8'h55, 1'b0);
    checks++;
    if (out_data !== 8'h11 || out_last !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL ovr_hold: got data=%h last=%b valid=%b required 11/0/1", out_data, out_last, out_valid);
    end
    checks++;
    if (ovr_total - ov0 != 2) begin failures++; $display("FAIL ovr_count: got %0d pulses required 2", ovr_total - ov0); end
    out_ready = 1'b1;
    wait_idle(expired);
    checks++;
    if (expired) begin failures++; $display("FAIL ovr_idle: busy still %b after budget, required 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL ovr_sb: got nothing required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL ovr_sb: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL ovr_extra: got %0d extra items (first %h) required 0", obs_q.size(), obs_q[0]); obs_q.delete(); end
  endtask

  task automatic test_reset_mid_drain();
    bit expired; logic [11:0] e, o;
    out_ready = 1'b0;
    exp_q.push_back(mk_ok());
    send_frame('{8'hA5, 8'h02, 8'h40, 8'h41, 8'h03});
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rst_pre: got valid=%b busy=%b required 1/1", out_valid, busy); end
    reset = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_last, frame_ok, frame_err, overrun, busy, err_code, out_data} !== 16'h0) begin
      failures++; $display("FAIL rst_mid_drain: got v=%b l=%b busy=%b code=%0d data=%h required all zero",
                           out_valid, out_last, busy, err_code, out_data);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_q.push_back(mk_ok());
    exp_q.push_back(mk_byte(1'b0, 8'hC3));
    exp_q.push_back(mk_byte(1'b1, 8'h3C));
    send_frame('{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD});
    wait_idle(expired);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL rst_sb: got nothing required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin failures++; $display("FAIL rst_sb: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL rst_extra: got %0d extra items (first %h) required 0", obs_q.size(), obs_q[0]); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_length();
    test_garbage();
    test_framing_timeout();
    test_overrun();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
